// File: rtl/e_reg_ctl.sv
// Decode->execute pipeline register with stall, bubble, conflict flag and optional exception freeze.
// Optional performance counters are enabled by defining E_REG_CTL_PERF_EN.
module e_reg_ctl #(
   parameter int               WORD_W        = 64,
   parameter int               REG_W         = 4,
   parameter logic [3:0]       NOP_ICODE     = 4'h1,
   parameter logic [2:0]       SAOK          = 3'h1,
   parameter logic [REG_W-1:0] RNONE         = REG_W'(4'hF),
   parameter bit               FREEZE_ON_EXC = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              e_stall,
   input  logic              e_bubble,
   input  logic [2:0]        d_stat,
   input  logic [3:0]        d_icode,
   input  logic [3:0]        d_ifun,
   input  logic [REG_W-1:0]  d_rA,
   input  logic [REG_W-1:0]  d_rB,
   input  logic [WORD_W-1:0] d_valC,
   input  logic [WORD_W-1:0] d_valP,
   input  logic [WORD_W-1:0] d_valA,
   input  logic [WORD_W-1:0] d_valB,
   output logic [2:0]        e_stat,
   output logic [3:0]        e_icode,
   output logic [3:0]        e_ifun,
   output logic [REG_W-1:0]  e_rA,
   output logic [REG_W-1:0]  e_rB,
   output logic [WORD_W-1:0] e_valC,
   output logic [WORD_W-1:0] e_valP,
   output logic [WORD_W-1:0] e_valA,
   output logic [WORD_W-1:0] e_valB,
   output logic              e_valid,
   output logic              e_ctl_err,
   output logic              e_frozen
`ifdef E_REG_CTL_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_bubble_cnt,
   output logic [31:0]       perf_instr_cnt
`endif
);

   logic [2:0]        r_stat;
   logic [3:0]        r_icode;
   logic [3:0]        r_ifun;
   logic [REG_W-1:0]  r_rA;
   logic [REG_W-1:0]  r_rB;
   logic [WORD_W-1:0] r_valC;
   logic [WORD_W-1:0] r_valP;
   logic [WORD_W-1:0] r_valA;
   logic [WORD_W-1:0] r_valB;
   logic              r_valid;
   logic              r_ctlErr;
   logic              r_frozen;

   logic w_doBubble;
   logic w_doStall;
   logic w_doCapture;

   // Freeze outranks bubble, which outranks stall; capture only when nothing else applies.
   assign w_doBubble  = !r_frozen && e_bubble;
   assign w_doStall   = !r_frozen && !e_bubble && e_stall;
   assign w_doCapture = !r_frozen && !e_bubble && !e_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat  <= SAOK;
         r_icode <= NOP_ICODE;
         r_ifun  <= 4'h0;
         r_rA    <= RNONE;
         r_rB    <= RNONE;
         r_valC  <= '0;
         r_valP  <= '0;
         r_valA  <= '0;
         r_valB  <= '0;
         r_valid <= 1'b0;
      end else if (w_doBubble) begin
         r_stat  <= SAOK;
         r_icode <= NOP_ICODE;
         r_ifun  <= 4'h0;
         r_rA    <= RNONE;
         r_rB    <= RNONE;
         r_valC  <= '0;
         r_valP  <= '0;
         r_valA  <= '0;
         r_valB  <= '0;
         r_valid <= 1'b0;
      end else if (w_doCapture) begin
         r_stat  <= d_stat;
         r_icode <= d_icode;
         r_ifun  <= d_ifun;
         r_rA    <= d_rA;
         r_rB    <= d_rB;
         r_valC  <= d_valC;
         r_valP  <= d_valP;
         r_valA  <= d_valA;
         r_valB  <= d_valB;
         r_valid <= 1'b1;
      end
   end

   // The conflict flag reports a hazard-unit fault, so it latches whatever state the register is in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctlErr <= 1'b0;
         r_frozen <= 1'b0;
      end else begin
         if (e_stall && e_bubble) begin
            r_ctlErr <= 1'b1;
         end
         if (FREEZE_ON_EXC && w_doCapture && (d_stat != SAOK)) begin
            r_frozen <= 1'b1;
         end
      end
   end

`ifdef E_REG_CTL_PERF_EN
   logic [31:0] r_stallCnt;
   logic [31:0] r_bubbleCnt;
   logic [31:0] r_instrCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCnt  <= '0;
         r_bubbleCnt <= '0;
         r_instrCnt  <= '0;
      end else begin
         if (w_doStall)   r_stallCnt  <= r_stallCnt + 32'd1;
         if (w_doBubble)  r_bubbleCnt <= r_bubbleCnt + 32'd1;
         if (w_doCapture) r_instrCnt  <= r_instrCnt + 32'd1;
      end
   end

   assign perf_stall_cnt  = r_stallCnt;
   assign perf_bubble_cnt = r_bubbleCnt;
   assign perf_instr_cnt  = r_instrCnt;
`else
   logic w_unusedStall;
   assign w_unusedStall = w_doStall;
`endif

   assign e_stat    = r_stat;
   assign e_icode   = r_icode;
   assign e_ifun    = r_ifun;
   assign e_rA      = r_rA;
   assign e_rB      = r_rB;
   assign e_valC    = r_valC;
   assign e_valP    = r_valP;
   assign e_valA    = r_valA;
   assign e_valB    = r_valB;
   assign e_valid   = r_valid;
   assign e_ctl_err = r_ctlErr;
   assign e_frozen  = r_frozen;

endmodule

// File: tb/tb_e_reg_ctl.sv
// Self-checking bench for e_reg_ctl: one instance without and one with exception freeze,
// both compared against a rule-level reference model.
module tb_e_reg_ctl;

   localparam int VW = 3 + 4 + 4 + 4 + 4 + 4 * 64 + 3;
   typedef logic [VW-1:0] vec_t;

   typedef struct {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  rA;
      logic [3:0]  rB;
      logic [63:0] valC;
      logic [63:0] valP;
      logic [63:0] valA;
      logic [63:0] valB;
      logic        valid;
      logic        err;
      logic        frozen;
      logic [31:0] nStall;
      logic [31:0] nBubble;
      logic [31:0] nInstr;
   } mstate_t;

   logic        clk;
   logic        rst_n;
   logic        e_stall;
   logic        e_bubble;
   logic [2:0]  d_stat;
   logic [3:0]  d_icode;
   logic [3:0]  d_ifun;
   logic [3:0]  d_rA;
   logic [3:0]  d_rB;
   logic [63:0] d_valC;
   logic [63:0] d_valP;
   logic [63:0] d_valA;
   logic [63:0] d_valB;

   logic [2:0]  e_stat0, e_stat1;
   logic [3:0]  e_icode0, e_icode1, e_ifun0, e_ifun1;
   logic [3:0]  e_rA0, e_rA1, e_rB0, e_rB1;
   logic [63:0] e_valC0, e_valC1, e_valP0, e_valP1;
   logic [63:0] e_valA0, e_valA1, e_valB0, e_valB1;
   logic        e_valid0, e_valid1, e_ctl_err0, e_ctl_err1, e_frozen0, e_frozen1;
`ifdef E_REG_CTL_PERF_EN
   logic [31:0] pStall0, pBubble0, pInstr0, pStall1, pBubble1, pInstr1;
`endif

   mstate_t m0;
   mstate_t m1;
   int nChecks = 0;
   int nFails  = 0;

   e_reg_ctl #(.FREEZE_ON_EXC(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .e_stall(e_stall), .e_bubble(e_bubble),
      .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
      .d_valC(d_valC), .d_valP(d_valP), .d_valA(d_valA), .d_valB(d_valB),
      .e_stat(e_stat0), .e_icode(e_icode0), .e_ifun(e_ifun0), .e_rA(e_rA0), .e_rB(e_rB0),
      .e_valC(e_valC0), .e_valP(e_valP0), .e_valA(e_valA0), .e_valB(e_valB0),
      .e_valid(e_valid0), .e_ctl_err(e_ctl_err0), .e_frozen(e_frozen0)
`ifdef E_REG_CTL_PERF_EN
      , .perf_stall_cnt(pStall0), .perf_bubble_cnt(pBubble0), .perf_instr_cnt(pInstr0)
`endif
   );

   e_reg_ctl #(.FREEZE_ON_EXC(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .e_stall(e_stall), .e_bubble(e_bubble),
      .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
      .d_valC(d_valC), .d_valP(d_valP), .d_valA(d_valA), .d_valB(d_valB),
      .e_stat(e_stat1), .e_icode(e_icode1), .e_ifun(e_ifun1), .e_rA(e_rA1), .e_rB(e_rB1),
      .e_valC(e_valC1), .e_valP(e_valP1), .e_valA(e_valA1), .e_valB(e_valB1),
      .e_valid(e_valid1), .e_ctl_err(e_ctl_err1), .e_frozen(e_frozen1)
`ifdef E_REG_CTL_PERF_EN
      , .perf_stall_cnt(pStall1), .perf_bubble_cnt(pBubble1), .perf_instr_cnt(pInstr1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the empty register holds a NOP bubble with all counters cleared.
   function automatic mstate_t resetModel();
      mstate_t s;
      s.stat = 3'h1;  s.icode = 4'h1; s.ifun = 4'h0; s.rA = 4'hF; s.rB = 4'hF;
      s.valC = '0;    s.valP = '0;    s.valA = '0;   s.valB = '0;
      s.valid = 1'b0; s.err = 1'b0;   s.frozen = 1'b0;
      s.nStall = '0;  s.nBubble = '0; s.nInstr = '0;
      return s;
   endfunction

   // One clock edge of the architectural rules, applied to whatever inputs are present.
   function automatic mstate_t modelStep(input mstate_t s, input bit freezeEn);
      mstate_t n;
      mstate_t b;
      n = s;
      if (e_stall && e_bubble) n.err = 1'b1;
      if (s.frozen) return n;
      if (e_bubble) begin
         b = resetModel();
         n.stat = b.stat; n.icode = b.icode; n.ifun = b.ifun; n.rA = b.rA; n.rB = b.rB;
         n.valC = b.valC; n.valP = b.valP; n.valA = b.valA; n.valB = b.valB;
         n.valid = 1'b0;
         n.nBubble = s.nBubble + 1;
      end else if (e_stall) begin
         n.nStall = s.nStall + 1;
      end else begin
         n.stat = d_stat; n.icode = d_icode; n.ifun = d_ifun; n.rA = d_rA; n.rB = d_rB;
         n.valC = d_valC; n.valP = d_valP; n.valA = d_valA; n.valB = d_valB;
         n.valid = 1'b1;
         n.nInstr = s.nInstr + 1;
         if (freezeEn && d_stat != 3'h1) n.frozen = 1'b1;
      end
      return n;
   endfunction

   function automatic vec_t packModel(input mstate_t s);
      return {s.stat, s.icode, s.ifun, s.rA, s.rB, s.valC, s.valP, s.valA, s.valB,
              s.valid, s.err, s.frozen};
   endfunction

   function automatic vec_t packOut0();
      return {e_stat0, e_icode0, e_ifun0, e_rA0, e_rB0, e_valC0, e_valP0, e_valA0, e_valB0,
              e_valid0, e_ctl_err0, e_frozen0};
   endfunction

   function automatic vec_t packOut1();
      return {e_stat1, e_icode1, e_ifun1, e_rA1, e_rB1, e_valC1, e_valP1, e_valA1, e_valB1,
              e_valid1, e_ctl_err1, e_frozen1};
   endfunction

   // Advance one edge; inputs were settled 1 time unit after the previous edge.
   task automatic tick();
      @(posedge clk);
      m0 = modelStep(m0, 1'b0);
      m1 = modelStep(m1, 1'b1);
      #1;
   endtask

   task automatic assertReset();
      rst_n = 1'b0;
      #1;
      m0 = resetModel();
      m1 = resetModel();
   endtask

   task automatic releaseReset();
      #2;
      rst_n = 1'b1;
   endtask

   task automatic driveInstr(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] va);
      d_stat = st; d_icode = ic; d_ifun = 4'h0; d_rA = 4'h2; d_rB = 4'h3;
      d_valC = 64'h100; d_valP = 64'h20A; d_valA = va; d_valB = 64'h7;
   endtask

   task automatic test_reset();
      releaseReset();
      driveInstr(3'h1, 4'h6, 64'h5);
      tick();
      tick();
      #2;
      assertReset();
      nChecks++;
      if (e_icode0 !== 4'h1 || e_stat0 !== 3'h1 || e_rA0 !== 4'hF || e_rB0 !== 4'hF ||
          e_valA0 !== 64'h0 || e_valid0 !== 1'b0 || e_ctl_err0 !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL reset_async: got icode=%h stat=%h rA=%h rB=%h valA=%h valid=%b err=%b, expected 1 1 f f 0 0 0",
                  e_icode0, e_stat0, e_rA0, e_rB0, e_valA0, e_valid0, e_ctl_err0);
      end
      nChecks++;
      if (packOut1() !== packModel(m1)) begin
         nFails++;
         $display("[TB] FAIL reset_freeze_inst: got %h expected %h", packOut1(), packModel(m1));
      end
      releaseReset();
   endtask

   task automatic test_capture();
      e_stall = 1'b0; e_bubble = 1'b0;
      driveInstr(3'h1, 4'h6, 64'h5);
      tick();
      nChecks++;
      if (e_icode0 !== 4'h6 || e_ifun0 !== 4'h0 || e_rA0 !== 4'h2 || e_rB0 !== 4'h3 ||
          e_valA0 !== 64'h5 || e_valB0 !== 64'h7 || e_valid0 !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL capture_fields: got icode=%h rA=%h rB=%h valA=%h valB=%h valid=%b, expected 6 2 3 5 7 1",
                  e_icode0, e_rA0, e_rB0, e_valA0, e_valB0, e_valid0);
      end
      nChecks++;
      if (packOut0() !== packModel(m0) || packOut1() !== packModel(m1)) begin
         nFails++;
         $display("[TB] FAIL capture_model: got %h / %h expected %h", packOut0(), packOut1(), packModel(m0));
      end
   endtask

   task automatic test_stall();
      e_stall = 1'b1;
      d_icode = 4'h3; d_valA = 64'hDEAD; d_valB = 'x;
      for (int i = 0; i < 3; i++) begin
         tick();
         nChecks++;
         if (e_icode0 !== 4'h6 || e_valA0 !== 64'h5 || e_valB0 !== 64'h7 || e_valid0 !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL stall_hold[%0d]: got icode=%h valA=%h valB=%h valid=%b, expected 6 5 7 1",
                     i, e_icode0, e_valA0, e_valB0, e_valid0);
         end
      end
      e_stall = 1'b0; d_valB = 64'h9;
      tick();
      nChecks++;
      if (e_icode0 !== 4'h3 || e_valA0 !== 64'hDEAD || e_valB0 !== 64'h9) begin
         nFails++;
         $display("[TB] FAIL stall_release: got icode=%h valA=%h valB=%h, expected 3 dead 9",
                  e_icode0, e_valA0, e_valB0);
      end
   endtask

   task automatic test_bubble_conflict();
      e_bubble = 1'b1;
      tick();
      nChecks++;
      if (e_icode0 !== 4'h1 || e_rA0 !== 4'hF || e_valid0 !== 1'b0 || e_ctl_err0 !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL bubble_load: got icode=%h rA=%h valid=%b err=%b, expected 1 f 0 0",
                  e_icode0, e_rA0, e_valid0, e_ctl_err0);
      end
      driveInstr(3'h1, 4'h6, 64'h5);
      e_bubble = 1'b0;
      tick();
      e_stall = 1'b1; e_bubble = 1'b1;
      tick();
      nChecks++;
      if (e_icode0 !== 4'h1 || e_valid0 !== 1'b0 || e_ctl_err0 !== 1'b1 || e_ctl_err1 !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL conflict_set: got icode=%h valid=%b err=%b/%b, expected 1 0 1/1",
                  e_icode0, e_valid0, e_ctl_err0, e_ctl_err1);
      end
      e_stall = 1'b0; e_bubble = 1'b0;
      tick();
      tick();
      nChecks++;
      if (e_ctl_err0 !== 1'b1 || e_icode0 !== 4'h6) begin
         nFails++;
         $display("[TB] FAIL conflict_sticky: got err=%b icode=%h, expected 1 6", e_ctl_err0, e_icode0);
      end
      e_stall = 1'b1;
      tick();
      #2;
      assertReset();
      nChecks++;
      if (e_ctl_err0 !== 1'b0 || e_valid0 !== 1'b0 || e_icode0 !== 4'h1) begin
         nFails++;
         $display("[TB] FAIL reset_mid_stall: got err=%b valid=%b icode=%h, expected 0 0 1",
                  e_ctl_err0, e_valid0, e_icode0);
      end
      releaseReset();
      e_stall = 1'b0;
      driveInstr(3'h1, 4'hA, 64'h33);
      tick();
      nChecks++;
      if (packOut0() !== packModel(m0) || e_icode0 !== 4'hA || e_valid0 !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL first_edge_after_reset: got %h expected %h", packOut0(), packModel(m0));
      end
   endtask

   task automatic test_freeze();
      e_stall = 1'b0; e_bubble = 1'b1;
      driveInstr(3'h3, 4'h5, 64'h11);
      tick();
      nChecks++;
      if (e_frozen1 !== 1'b0 || e_icode1 !== 4'h1) begin
         nFails++;
         $display("[TB] FAIL freeze_bubble_wins: got frozen=%b icode=%h, expected 0 1", e_frozen1, e_icode1);
      end
      e_bubble = 1'b0;
      tick();
      nChecks++;
      if (e_frozen1 !== 1'b1 || e_frozen0 !== 1'b0 || e_stat0 !== 3'h3) begin
         nFails++;
         $display("[TB] FAIL freeze_set: got frozen1=%b frozen0=%b stat0=%h, expected 1 0 3",
                  e_frozen1, e_frozen0, e_stat0);
      end
      driveInstr(3'h1, 4'h6, 64'h22);
      tick();
      e_bubble = 1'b1;
      tick();
      nChecks++;
      if (e_icode1 !== 4'h5 || e_stat1 !== 3'h3 || e_valid1 !== 1'b1 || e_icode0 !== 4'h1) begin
         nFails++;
         $display("[TB] FAIL freeze_hold: got icode1=%h stat1=%h valid1=%b icode0=%h, expected 5 3 1 1",
                  e_icode1, e_stat1, e_valid1, e_icode0);
      end
      e_bubble = 1'b0;
      #2;
      assertReset();
      nChecks++;
      if (e_frozen1 !== 1'b0 || packOut1() !== packModel(m1)) begin
         nFails++;
         $display("[TB] FAIL freeze_reset: got frozen=%b state=%h expected %h", e_frozen1, packOut1(), packModel(m1));
      end
      releaseReset();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 49) begin
            #2;
            assertReset();
            releaseReset();
         end
         e_stall  = ($urandom_range(0, 3) == 0);
         e_bubble = ($urandom_range(0, 6) == 0);
         d_stat   = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'h1;
         d_icode  = 4'($urandom);
         d_ifun   = 4'($urandom);
         d_rA     = 4'($urandom);
         d_rB     = 4'($urandom);
         d_valC   = {$urandom, $urandom};
         d_valP   = {$urandom, $urandom};
         d_valA   = {$urandom, $urandom};
         d_valB   = {$urandom, $urandom};
         tick();
         nChecks++;
         if (packOut0() !== packModel(m0)) begin
            nFails++;
            $display("[TB] FAIL random_nofreeze[%0d]: got %h expected %h", i, packOut0(), packModel(m0));
         end
         nChecks++;
         if (packOut1() !== packModel(m1)) begin
            nFails++;
            $display("[TB] FAIL random_freeze[%0d]: got %h expected %h", i, packOut1(), packModel(m1));
         end
`ifdef E_REG_CTL_PERF_EN
         nChecks++;
         if ({pStall0, pBubble0, pInstr0} !== {m0.nStall, m0.nBubble, m0.nInstr} ||
             {pStall1, pBubble1, pInstr1} !== {m1.nStall, m1.nBubble, m1.nInstr}) begin
            nFails++;
            $display("[TB] FAIL random_perf[%0d]: got %0d %0d %0d / %0d %0d %0d expected %0d %0d %0d / %0d %0d %0d",
                     i, pStall0, pBubble0, pInstr0, pStall1, pBubble1, pInstr1,
                     m0.nStall, m0.nBubble, m0.nInstr, m1.nStall, m1.nBubble, m1.nInstr);
         end
`endif
      end
      e_stall = 1'b0; e_bubble = 1'b0;
   endtask

`ifdef E_REG_CTL_PERF_EN
   task automatic test_perf();
      #2;
      assertReset();
      releaseReset();
      driveInstr(3'h1, 4'h6, 64'h5);
      e_stall = 1'b0; e_bubble = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      e_stall = 1'b1;
      for (int i = 0; i < 2; i++) tick();
      e_stall = 1'b0; e_bubble = 1'b1;
      tick();
      e_bubble = 1'b0;
      nChecks++;
      if (pInstr0 !== 32'd4 || pStall0 !== 32'd2 || pBubble0 !== 32'd1) begin
         nFails++;
         $display("[TB] FAIL perf_counts: got instr=%0d stall=%0d bubble=%0d, expected 4 2 1",
                  pInstr0, pStall0, pBubble0);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      e_stall = 1'b0;
      e_bubble = 1'b0;
      driveInstr(3'h1, 4'h1, 64'h0);
      m0 = resetModel();
      m1 = resetModel();
      #3;
      test_reset();
      test_capture();
      test_stall();
      test_bubble_conflict();
      test_freeze();
      test_random();
`ifdef E_REG_CTL_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
